uart_multi_top: RTL and testbench

N-channel, wishbone-slave UART top. It is the parametrised successor to the single-channel 16550 wrapper. Each channel has fixed 8N1 framing, a programmable 16x-oversample baud divisor, and TX/RX FIFOs of parametrised depth. A shared register decoder serves all channels, and per-channel interrupt sources are OR-reduced onto one intr_o. It sits on the system wishbone bus beside the clk_rst_manager.

---
 rtl/uart_multi_top.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_multi_top.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_multi_top.sv
// N-channel 8N1 UART behind a shared wishbone register decoder; one interrupt line for all channels.
// Optional macro UART_FLOW_CTRL_EN enables CTS-gated transmit and RTS from RX FIFO fill level.
module uart_multi_top #(
  parameter int          CHANNELS   = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd53
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [15:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic                stb_i,
  input  logic                cyc_i,
  output logic                ack_o,
  output logic                intr_o,
  output logic [CHANNELS-1:0] stx_o,
  input  logic [CHANNELS-1:0] srx_i,
  output logic [CHANNELS-1:0] rts_o,
  input  logic [CHANNELS-1:0] cts_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  logic        ack_reg, intr_reg;
  logic [31:0] dat_reg, rdata;
  logic        req;
  logic [31:0] status_w [16];
  logic [31:0] ctrl_w [16];
  logic [7:0]  rxd_w [16];
  logic [CHANNELS-1:0] intr_w, rts_w;
  logic        unused_bits;

  assign req    = stb_i & cyc_i & ~ack_reg;
  assign ack_o  = ack_reg;
  assign dat_o  = dat_reg;
  assign intr_o = intr_reg;
  assign rts_o  = rts_w;
  assign unused_bits = ^{adr_i[15:8], adr_i[1:0], sel_i[3:1], dat_i[15:8]};

  // Unused channel slots read as zero, which covers out-of-range channel reads.
  always_comb begin
    rdata = 32'd0;
    case (adr_i[3:2])
      2'd0: rdata = {24'd0, rxd_w[adr_i[7:4]]};
      2'd1: rdata = status_w[adr_i[7:4]];
      2'd2: rdata = ctrl_w[adr_i[7:4]];
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_reg  <= 1'b0;
      dat_reg  <= 32'd0;
      intr_reg <= 1'b0;
    end else begin
      ack_reg  <= req;
      dat_reg  <= (req & ~we_i) ? rdata : 32'd0;
      intr_reg <= |intr_w;
    end
  end

  genvar gi;
  for (gi = CHANNELS; gi < 16; gi++) begin : g_pad
    assign status_w[gi] = 32'd0;
    assign ctrl_w[gi]   = 32'd0;
    assign rxd_w[gi]    = 8'd0;
  end

  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic sel_ch, wr_data, rd_data, wr_status, wr_ctrl;
    logic rx_ie_reg, tx_ie_reg, en_reg;
    logic [15:0] div_reg, baud_cnt_reg;
    logic tick, cts_ok;
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg, tx_count, rx_count;
    logic tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_store, tx_idle_empty;
    uart_state_t tx_state_reg, tx_state_next, rx_state_reg, rx_state_next;
    logic [3:0] tx_tick_reg, rx_tick_reg;
    logic [2:0] tx_bit_reg, rx_bit_reg;
    logic [7:0] tx_shift_reg, rx_shift_reg;
    logic tx_bit_end, can_start, rx_mid, rx_end;
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg, overrun_reg, frame_err_reg;

    assign sel_ch    = req & (adr_i[7:4] == 4'(gi));
    assign wr_data   = sel_ch & we_i & (adr_i[3:2] == 2'd0) & sel_i[0];
    assign rd_data   = sel_ch & ~we_i & (adr_i[3:2] == 2'd0);
    assign wr_status = sel_ch & we_i & (adr_i[3:2] == 2'd1);
    assign wr_ctrl   = sel_ch & we_i & (adr_i[3:2] == 2'd2);

    assign tx_count      = tx_wr_ptr_reg - tx_rd_ptr_reg;
    assign rx_count      = rx_wr_ptr_reg - rx_rd_ptr_reg;
    assign tx_fifo_empty = (tx_count == '0);
    assign rx_fifo_empty = (rx_count == '0);
    assign tx_fifo_full  = (tx_count == PW'(FIFO_DEPTH));
    assign rx_fifo_full  = (rx_count == PW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_push  = wr_data & (~tx_fifo_full | tx_pop);
    assign rx_pop   = rd_data & ~rx_fifo_empty;
    assign rx_store = rx_push & (~rx_fifo_full | rx_pop);
    assign tx_idle_empty = tx_fifo_empty & (tx_state_reg == ST_IDLE);

    assign tick       = (baud_cnt_reg == 16'd0);
    assign can_start  = en_reg & ~tx_fifo_empty & cts_ok;
    assign tx_bit_end = tick & (tx_tick_reg == 4'd15);
    assign rx_mid     = tick & (rx_tick_reg == 4'd7);
    assign rx_end     = tick & (rx_tick_reg == 4'd15);

    assign stx_o[gi]    = (tx_state_reg == ST_START) ? 1'b0 :
                          (tx_state_reg == ST_DATA) ? tx_shift_reg[0] : 1'b1;
    assign rxd_w[gi]    = rx_fifo_empty ? 8'd0 : rx_mem[rx_rd_ptr_reg[AW-1:0]];
    assign status_w[gi] = {8'd0, 8'(tx_count), 8'(rx_count), 2'b00, frame_err_reg, overrun_reg,
                           tx_fifo_full, tx_idle_empty, rx_fifo_full, ~rx_fifo_empty};
    assign ctrl_w[gi]   = {div_reg, 13'd0, en_reg, tx_ie_reg, rx_ie_reg};
    assign intr_w[gi]   = (rx_ie_reg & ~rx_fifo_empty) | (tx_ie_reg & tx_idle_empty) |
                          overrun_reg | frame_err_reg;

    always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wr_ptr_reg[AW-1:0]] <= dat_i[7:0];
      if (rx_store) rx_mem[rx_wr_ptr_reg[AW-1:0]] <= rx_shift_reg;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        {rx_ie_reg, tx_ie_reg, en_reg} <= 3'b000;
        div_reg       <= DIV_RESET;
        baud_cnt_reg  <= DIV_RESET;
        tx_wr_ptr_reg <= '0;
        tx_rd_ptr_reg <= '0;
        rx_wr_ptr_reg <= '0;
        rx_rd_ptr_reg <= '0;
        overrun_reg   <= 1'b0;
        frame_err_reg <= 1'b0;
        rx_meta_reg   <= 1'b1;
        rx_sync_reg   <= 1'b1;
        rx_prev_reg   <= 1'b1;
      end else begin
        if (wr_ctrl) begin
          {en_reg, tx_ie_reg, rx_ie_reg} <= dat_i[2:0];
          div_reg      <= dat_i[31:16];
          baud_cnt_reg <= dat_i[31:16];
        end else if (tick) begin
          baud_cnt_reg <= div_reg;
        end else begin
          baud_cnt_reg <= baud_cnt_reg - 16'd1;
        end
        if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PW'(1);
        if (tx_pop) tx_rd_ptr_reg <= tx_rd_ptr_reg + PW'(1);
        if (rx_store) rx_wr_ptr_reg <= rx_wr_ptr_reg + PW'(1);
        if (rx_pop) rx_rd_ptr_reg <= rx_rd_ptr_reg + PW'(1);
        // A new error in the same cycle as a W1C keeps the flag set.
        overrun_reg   <= (overrun_reg & ~(wr_status & dat_i[4])) | (rx_push & ~rx_store);
        frame_err_reg <= (frame_err_reg & ~(wr_status & dat_i[5])) | (rx_push & ~rx_sync_reg);
        rx_meta_reg <= srx_i[gi];
        rx_sync_reg <= rx_meta_reg;
        rx_prev_reg <= rx_sync_reg;
      end
    end

    always_comb begin
      tx_state_next = tx_state_reg;
      tx_pop        = 1'b0;
      case (tx_state_reg)
        ST_IDLE:  if (can_start) begin tx_state_next = ST_START; tx_pop = 1'b1; end
        ST_START: if (tx_bit_end) tx_state_next = ST_DATA;
        ST_DATA:  if (tx_bit_end && tx_bit_reg == 3'd7) tx_state_next = ST_STOP;
        ST_STOP: begin
          if (tx_bit_end) begin
            tx_state_next = can_start ? ST_START : ST_IDLE;
            tx_pop        = can_start;
          end
        end
        default: tx_state_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        tx_state_reg <= ST_IDLE;
        tx_tick_reg  <= 4'd0;
        tx_bit_reg   <= 3'd0;
        tx_shift_reg <= 8'd0;
      end else begin
        tx_state_reg <= tx_state_next;
        if (tx_pop) begin
          tx_shift_reg <= tx_mem[tx_rd_ptr_reg[AW-1:0]];
          tx_tick_reg  <= 4'd0;
          tx_bit_reg   <= 3'd0;
        end else if (tx_state_reg != ST_IDLE && tick) begin
          tx_tick_reg <= tx_tick_reg + 4'd1;
          if (tx_bit_end && tx_state_reg == ST_DATA) begin
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_bit_reg   <= tx_bit_reg + 3'd1;
          end
        end
      end
    end

    // Start bit is checked at its 8th tick; every later bit is sampled 16 ticks after that.
    always_comb begin
      rx_state_next = rx_state_reg;
      rx_push       = 1'b0;
      case (rx_state_reg)
        ST_IDLE:  if (rx_prev_reg && !rx_sync_reg) rx_state_next = ST_START;
        ST_START: if (rx_mid) rx_state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
        ST_DATA:  if (rx_end && rx_bit_reg == 3'd7) rx_state_next = ST_STOP;
        ST_STOP:  if (rx_end) begin rx_state_next = ST_IDLE; rx_push = 1'b1; end
        default:  rx_state_next = ST_IDLE;
      endcase
      if (!en_reg) begin
        rx_state_next = ST_IDLE;
        rx_push       = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rx_state_reg <= ST_IDLE;
        rx_tick_reg  <= 4'd0;
        rx_bit_reg   <= 3'd0;
        rx_shift_reg <= 8'd0;
      end else begin
        rx_state_reg <= rx_state_next;
        if (rx_state_reg == ST_IDLE || (rx_state_reg == ST_START && rx_mid)) rx_tick_reg <= 4'd0;
        else if (tick) rx_tick_reg <= rx_tick_reg + 4'd1;
        if (rx_state_reg == ST_IDLE) rx_bit_reg <= 3'd0;
        else if (rx_state_reg == ST_DATA && rx_end) begin
          rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
          rx_bit_reg   <= rx_bit_reg + 3'd1;
        end
      end
    end

`ifdef UART_FLOW_CTRL_EN
    logic cts_meta_reg, cts_sync_reg, rts_reg;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cts_meta_reg <= 1'b0;
        cts_sync_reg <= 1'b0;
        rts_reg      <= 1'b1;
      end else begin
        cts_meta_reg <= cts_i[gi];
        cts_sync_reg <= cts_meta_reg;
        rts_reg      <= ~(rx_count >= PW'(FIFO_DEPTH - 2));
      end
    end
    assign cts_ok    = cts_sync_reg;
    assign rts_w[gi] = rts_reg;
`else
    assign cts_ok    = 1'b1;
    assign rts_w[gi] = 1'b1;
`endif
  end

`ifndef UART_FLOW_CTRL_EN
  logic unused_cts;
  assign unused_cts = ^cts_i;
`endif
endmodule

// File: tb/tb_uart_multi_top.sv
// Directed self-checking bench for uart_multi_top (4 channels, 16-deep FIFOs, default build).
module tb_uart_multi_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adr;
  logic [31:0] wdat, rdat;
  logic        we, stb, cyc_s, ack, intr;
  logic [3:0]  sel, stx, srx, rts, cts, srx_drv, loop_mask;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign srx = (srx_drv & ~loop_mask) | (stx & loop_mask);

  uart_multi_top #(.CHANNELS(4), .FIFO_DEPTH(16), .DIV_RESET(16'd53)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(rdat), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc_s), .ack_o(ack), .intr_o(intr),
    .stx_o(stx), .srx_i(srx), .rts_o(rts), .cts_i(cts)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic [15:0] a, input logic w, input logic [31:0] d, output logic [31:0] q);
    logic got = 1'b0;
    q = 32'd0;
    adr = a; we = w; wdat = d; sel = 4'hF; stb = 1'b1; cyc_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick_n(1);
      if (ack) begin got = 1'b1; q = rdat; break; end
    end
    stb = 1'b0; cyc_s = 1'b0; we = 1'b0;
    if (!got) check_val("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_op(a, 1'b1, d, q);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] q);
    bus_op(a, 1'b0, 32'd0, q);
  endtask

  task automatic wait_low(input int ch);
    logic seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick_n(1);
      if (!stx[ch]) begin seen = 1'b1; break; end
    end
    if (!seen) check_val("tx_start_timeout", 32'd0, 32'd1);
  endtask

  // Called one step after the edge that entered the start bit; samples each bit mid-way.
  task automatic get_frame(input int ch, output logic [9:0] v);
    for (int k = 0; k < 10; k++) begin
      tick_n(k == 0 ? 8 : 16);
      v[k] = stx[ch];
    end
  endtask

  task automatic send_frame(input int ch, input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      srx_drv[ch] = bits[k];
      tick_n(16);
    end
    srx_drv[ch] = 1'b1;
    tick_n(4);
  endtask

  initial begin
    logic [31:0] q;
    logic [9:0]  fr;
    rst = 1'b1; adr = 16'd0; wdat = 32'd0; we = 1'b0; stb = 1'b0; cyc_s = 1'b0; sel = 4'h0;
    srx_drv = 4'hF; cts = 4'hF; loop_mask = 4'h0;
    tick_n(3);
    check_val("rst_ack", {31'd0, ack}, 32'd0);
    check_val("rst_dat", rdat, 32'd0);
    rst = 1'b0;
    tick_n(1);
    check_val("rst_intr", {31'd0, intr}, 32'd0);
    check_val("rst_stx", {28'd0, stx}, 32'hF);
    check_val("rst_rts", {28'd0, rts}, 32'hF);
    bus_read(16'h0008, q); check_val("ch0_ctrl_rst", q, 32'h0035_0000);
    bus_read(16'h0024, q); check_val("ch2_status_rst", q, 32'h0000_0004);
    bus_read(16'h0048, q); check_val("ch4_ctrl_invalid", q, 32'd0);
    bus_read(16'h000C, q); check_val("ch0_reg_c", q, 32'd0);

    // Loopback on channel 1
    loop_mask = 4'b0010;
    bus_write(16'h0018, 32'h0000_0004);
    bus_write(16'h0010, 32'h0000_00A5);
    wait_low(1);
    get_frame(1, fr);
    check_val("lb_frame_bits", {22'd0, fr}, 32'h0000_034A);
    tick_n(30);
    bus_read(16'h0014, q); check_val("lb_status_full1", q, 32'h0000_0105);
    bus_read(16'h0010, q); check_val("lb_rx_byte", q, 32'h0000_00A5);
    bus_read(16'h0014, q); check_val("lb_status_after_pop", q, 32'h0000_0004);
    loop_mask = 4'b0000;

    // Overrun on channel 0
    bus_write(16'h0008, 32'h0000_0004);
    for (int i = 0; i < 17; i++) send_frame(0, 8'h10 + 8'(i), 1'b1);
    bus_read(16'h0004, q); check_val("ovr_status", q, 32'h0000_1017);
    check_val("ovr_intr", {31'd0, intr}, 32'd1);
    bus_write(16'h0004, 32'h0000_0010);
    tick_n(1);
    bus_read(16'h0004, q); check_val("ovr_w1c_status", q, 32'h0000_1007);
    check_val("ovr_w1c_intr", {31'd0, intr}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus_read(16'h0000, q);
      if (i == 0) check_val("ovr_first_byte", q, 32'h0000_0010);
      if (i == 15) check_val("ovr_16th_byte", q, 32'h0000_001F);
    end
    bus_read(16'h0000, q); check_val("ovr_empty_read", q, 32'd0);

    // Glitch, then framing error on channel 0
    srx_drv[0] = 1'b0; tick_n(4); srx_drv[0] = 1'b1; tick_n(40);
    bus_read(16'h0004, q); check_val("glitch_status", q, 32'h0000_0004);
    send_frame(0, 8'h3C, 1'b0);
    tick_n(4);
    bus_read(16'h0004, q); check_val("ferr_status", q, 32'h0000_0125);
    check_val("ferr_intr", {31'd0, intr}, 32'd1);
    bus_read(16'h0000, q); check_val("ferr_byte", q, 32'h0000_003C);
    bus_write(16'h0004, 32'h0000_0020);
    bus_read(16'h0004, q); check_val("ferr_w1c_status", q, 32'h0000_0004);

    // TX full and back-to-back frames on channel 3
    for (int i = 0; i < 17; i++) bus_write(16'h0030, 32'h40 + 32'(i));
    bus_read(16'h0034, q); check_val("txfull_status", q, 32'h0010_0008);
    bus_write(16'h0038, 32'h0000_0006);
    wait_low(3);
    for (int f = 0; f < 16; f++) begin
      if (f != 0) tick_n(8);
      get_frame(3, fr);
      check_val($sformatf("b2b_frame%0d", f), {22'd0, fr}, {22'd0, 1'b1, 8'h40 + 8'(f), 1'b0});
    end
    tick_n(8);
    check_val("b2b_intr_at_end", {31'd0, intr}, 32'd0);
    check_val("b2b_stx_idle", {31'd0, stx[3]}, 32'd1);
    tick_n(1);
    check_val("b2b_intr_rise", {31'd0, intr}, 32'd1);
    bus_read(16'h0034, q); check_val("b2b_status_end", q, 32'h0000_0004);
    check_val("rts_const", {28'd0, rts}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
